wb_fetch_scheduler: RTL and testbench

//  Shares the single weight-buffer (WB) SRAM read port among the three weight streams of processing_unit:

---
 rtl/wb_fetch_scheduler_pkg.sv | 25 ++
 rtl/wb_fetch_scheduler_rr_arbiter3.sv | 38 +++
 rtl/wb_fetch_scheduler.sv | 157 +++++++++++++++
 tb/tb_wb_fetch_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// wb_fetch_scheduler_pkg : channel ids and FSM encoding for the WB fetch path
// Revision 1.0
// ============================================================================
package wb_fetch_scheduler_pkg;

  localparam int CH_IDX    = 0;
  localparam int CH_UNIQ   = 1;
  localparam int CH_REP    = 2;
  localparam int NUM_WB_CH = 3;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_ARB  = 2'd1;
  localparam logic [1:0] FS_WAIT = 2'd2;
  localparam logic [1:0] FS_DONE = 2'd3;

  function automatic logic [1:0] rr_next(input logic [1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fetch_scheduler_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// wb_fetch_scheduler_rr_arbiter3 : 3-way round-robin pick, first request after last
// Revision 1.0
// ============================================================================
module wb_fetch_scheduler_rr_arbiter3
  import wb_fetch_scheduler_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_idx_o,
  output logic       any_o
);

  logic [3:0] req_ext;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] cand3;

  assign req_ext = {1'b0, req_i};
  assign cand1   = rr_next(last_i);
  assign cand2   = rr_next(cand1);
  assign cand3   = rr_next(cand2);
  assign any_o   = |req_i;

  always_comb begin
    gnt_idx_o = cand1;
    if (req_ext[cand1]) begin
      gnt_idx_o = cand1;
    end else if (req_ext[cand2]) begin
      gnt_idx_o = cand2;
    end else if (req_ext[cand3]) begin
      gnt_idx_o = cand3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// wb_fetch_scheduler : shares the WB SRAM read port among the index, delta and
// repetition weight streams with one outstanding read and 1-word buffers.
// Revision 1.0
// ============================================================================
module wb_fetch_scheduler
  import wb_fetch_scheduler_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     idx_start_addr_i,
  input  logic [ADDR_W-1:0]     uniq_start_addr_i,
  input  logic [ADDR_W-1:0]     rep_start_addr_i,
  input  logic [3*CNT_W-1:0]    ch_len_i,
  output logic                  WB_SRAM_read_o,
  output logic [ADDR_W-1:0]     WB_SRAM_address_o,
  input  logic                  WB_SRAM_ready_i,
  input  logic [WORD_W-1:0]     WB_SRAM_in_i,
  output logic [2:0]            rsp_valid_o,
  input  logic [2:0]            rsp_ready_i,
  output logic [3*WORD_W-1:0]   rsp_data_o,
  output logic                  busy_o,
  output logic                  finished_o
);

  fetch_state_t      state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] base    [NUM_WB_CH];
  logic [ADDR_W-1:0] ptr_all [NUM_WB_CH];
  logic [2:0]        rem_nz;
  logic [2:0]        elig;
  logic [1:0]        arb_gnt;
  logic              arb_any;
  logic              load;
  logic              capture;

  assign base[CH_IDX]  = idx_start_addr_i;
  assign base[CH_UNIQ] = uniq_start_addr_i;
  assign base[CH_REP]  = rep_start_addr_i;

  assign load    = (state_q == FS_IDLE) && start_i;
  assign capture = (state_q == FS_WAIT) && WB_SRAM_ready_i;
  assign elig    = rem_nz & ~rsp_valid_o;

  for (genvar i = 0; i < NUM_WB_CH; i++) begin : g_ch
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              vld_q, vld_d;
    logic              hit;

    assign hit = capture && (gnt_q == 2'(i));

    // a fresh capture always wins over a same-cycle consumer accept
    always_comb begin
      ptr_d = ptr_q;
      rem_d = rem_q;
      buf_d = buf_q;
      vld_d = vld_q;
      if (vld_q && rsp_ready_i[i]) begin
        vld_d = 1'b0;
      end
      if (load) begin
        ptr_d = base[i];
        rem_d = ch_len_i[i*CNT_W +: CNT_W];
      end else if (hit) begin
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
        buf_d = WB_SRAM_in_i;
        vld_d = 1'b1;
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        ptr_q <= '0;
        rem_q <= '0;
        buf_q <= '0;
        vld_q <= 1'b0;
      end else begin
        ptr_q <= ptr_d;
        rem_q <= rem_d;
        buf_q <= buf_d;
        vld_q <= vld_d;
      end
    end

    assign ptr_all[i]                    = ptr_q;
    assign rem_nz[i]                     = (rem_q != '0);
    assign rsp_valid_o[i]                = vld_q;
    assign rsp_data_o[i*WORD_W +: WORD_W] = buf_q;
  end

  wb_fetch_scheduler_rr_arbiter3 u_arb (
    .req_i     (elig),
    .last_i    (rr_q),
    .gnt_idx_o (arb_gnt),
    .any_o     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    case (state_q)
      FS_IDLE: if (start_i) state_d = FS_ARB;
      FS_ARB: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          addr_d  = ptr_all[arb_gnt];
          state_d = FS_WAIT;
        end else if ((rem_nz == 3'b000) && (rsp_valid_o == 3'b000)) begin
          state_d = FS_DONE;
        end
      end
      FS_WAIT: begin
        if (WB_SRAM_ready_i) begin
          rr_d    = gnt_q;
          state_d = FS_ARB;
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FS_IDLE;
      rr_q    <= 2'd2;
      gnt_q   <= 2'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
    end
  end

  assign WB_SRAM_read_o    = (state_q == FS_WAIT);
  assign WB_SRAM_address_o = (state_q == FS_WAIT) ? addr_q : '0;
  assign busy_o            = (state_q == FS_ARB) || (state_q == FS_WAIT);
  assign finished_o        = (state_q == FS_DONE);

endmodule
`default_nettype wire

// File: tb/tb_wb_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// tb_wb_fetch_scheduler : directed table-driven bench for wb_fetch_scheduler
// Revision 1.0
// ============================================================================
module tb_wb_fetch_scheduler;

  localparam int WORD_W = 64;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic                clock_i = 1'b0;
  logic                reset_i = 1'b0;
  logic                start_i = 1'b0;
  logic [ADDR_W-1:0]   idx_start_addr_i  = '0;
  logic [ADDR_W-1:0]   uniq_start_addr_i = '0;
  logic [ADDR_W-1:0]   rep_start_addr_i  = '0;
  logic [3*CNT_W-1:0]  ch_len_i = '0;
  logic                WB_SRAM_read_o;
  logic [ADDR_W-1:0]   WB_SRAM_address_o;
  logic                sram_ready = 1'b0;
  logic [WORD_W-1:0]   sram_in = '0;
  logic [2:0]          rsp_valid_o;
  logic [2:0]          rsp_ready_i = 3'b111;
  logic [3*WORD_W-1:0] rsp_data_o;
  logic                busy_o;
  logic                finished_o;

  wb_fetch_scheduler #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .idx_start_addr_i  (idx_start_addr_i),
    .uniq_start_addr_i (uniq_start_addr_i),
    .rep_start_addr_i  (rep_start_addr_i),
    .ch_len_i          (ch_len_i),
    .WB_SRAM_read_o    (WB_SRAM_read_o),
    .WB_SRAM_address_o (WB_SRAM_address_o),
    .WB_SRAM_ready_i   (sram_ready),
    .WB_SRAM_in_i      (sram_in),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_data_o        (rsp_data_o),
    .busy_o            (busy_o),
    .finished_o        (finished_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [CNT_W-1:0]      len0, len1, len2;
    logic [31:0]           b0, b1, b2;
    int                    stall1;
    bit                    restart;
    bit                    no_reset;
    int                    n_exp;
    logic [3:0][31:0]      ea;
    int                    total;
  } vec_t;

  vec_t        tbl [6];
  int          n_cmp = 0;
  int          n_miss = 0;
  logic [31:0] cur_base [3];
  int          got [3];
  logic [31:0] addr_log [64];
  int          n_addr = 0;
  int          fin_cnt = 0;
  int          sram_lat = 1;
  int          wcnt = 0;
  logic [63:0] held = '0;
  bit          held_v = 1'b0;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic vec_t mk(input int l0, input int l1, input int l2,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                              input int stall1, input bit restart, input bit no_reset, input int n_exp,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3, input int total);
    vec_t v;
    v.len0 = CNT_W'(l0); v.len1 = CNT_W'(l1); v.len2 = CNT_W'(l2);
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.stall1 = stall1; v.restart = restart; v.no_reset = no_reset;
    v.n_exp = n_exp;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.total = total;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM model: ready after sram_lat wait cycles, data derived from the address
  initial begin
    forever begin
      @(posedge clock_i); #1;
      if (reset_i) begin
        sram_ready = 1'b0;
        wcnt = 0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
      end else if (WB_SRAM_read_o) begin
        if (wcnt >= sram_lat) begin
          sram_ready = 1'b1;
          sram_in = word_of(WB_SRAM_address_o);
          wcnt = 0;
          if (n_addr < 64) addr_log[n_addr] = WB_SRAM_address_o;
          n_addr++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // consumer side: every accepted word must be the next word of that channel
  initial begin
    forever begin
      @(negedge clock_i);
      if (finished_o) fin_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          chk($sformatf("rsp_data_ch%0d_word%0d", i, got[i]), rsp_data_o[i*64 +: 64],
              word_of(cur_base[i] + got[i]));
          got[i]++;
        end
      end
      if (rsp_valid_o[1] && !rsp_ready_i[1]) begin
        if (held_v) chk("ch1_hold_stable", rsp_data_o[127:64], held);
        held   = rsp_data_o[127:64];
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bit done_seen;
    if (!v.no_reset) do_reset();
    n_addr = 0; fin_cnt = 0; held_v = 1'b0;
    got[0] = 0; got[1] = 0; got[2] = 0;
    cur_base[0] = v.b0; cur_base[1] = v.b1; cur_base[2] = v.b2;
    idx_start_addr_i  = v.b0;
    uniq_start_addr_i = v.b1;
    rep_start_addr_i  = v.b2;
    ch_len_i          = {v.len2, v.len1, v.len0};
    rsp_ready_i       = (v.stall1 > 0) ? 3'b101 : 3'b111;
    @(posedge clock_i); #1; start_i = 1'b1;
    @(posedge clock_i); #1; start_i = 1'b0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (v.restart && cyc == 6) begin
        chk({tag, "_busy_at_restart"}, 64'(busy_o), 64'd1);
        idx_start_addr_i  = 32'hDEAD_0000;
        uniq_start_addr_i = 32'hDEAD_1000;
        rep_start_addr_i  = 32'hDEAD_2000;
        ch_len_i          = {3{CNT_W'(5)}};
        start_i           = 1'b1;
      end
      if (v.restart && cyc == 7) start_i = 1'b0;
      if (v.stall1 > 0 && cyc == v.stall1) begin
        chk({tag, "_stall_ch0_done"}, 64'(got[0]), 64'(v.len0));
        chk({tag, "_stall_ch2_done"}, 64'(got[2]), 64'(v.len2));
        chk({tag, "_stall_ch1_none"}, 64'(got[1]), 64'd0);
        chk({tag, "_stall_ch1_held"}, 64'(rsp_valid_o[1]), 64'd1);
        rsp_ready_i[1] = 1'b1;
      end
      @(posedge clock_i); #1;
      cyc++;
      if (finished_o) done_seen = 1'b1;
    end
    chk({tag, "_finished_seen"}, 64'(done_seen), 64'd1);
    repeat (3) @(posedge clock_i);
    #1;
    chk({tag, "_finished_once"}, 64'(fin_cnt), 64'd1);
    chk({tag, "_busy_after"},    64'(busy_o), 64'd0);
    chk({tag, "_words_ch0"},     64'(got[0]), 64'(v.len0));
    chk({tag, "_words_ch1"},     64'(got[1]), 64'(v.len1));
    chk({tag, "_words_ch2"},     64'(got[2]), 64'(v.len2));
    chk({tag, "_reads_total"},   64'(n_addr), 64'(v.total));
    for (int k = 0; k < v.n_exp; k++)
      chk($sformatf("%s_addr%0d", tag, k), 64'(addr_log[k]), 64'(v.ea[k]));
  endtask

  initial begin
    bit seen;
    tbl[0] = mk(2, 1, 1, 32'h0, 32'h1000_0000, 32'h2000_0000, 0, 0, 0, 4,
                32'h0, 32'h1000_0000, 32'h2000_0000, 32'h1, 4);
    tbl[1] = mk(3, 3, 3, 32'h0, 32'h1000_0000, 32'h2000_0000, 40, 0, 0, 4,
                32'h0, 32'h1000_0000, 32'h2000_0000, 32'h1, 9);
    tbl[2] = mk(2, 0, 0, 32'hFFFF_FFFF, 32'h10, 32'h20, 0, 0, 0, 2,
                32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 2);
    tbl[3] = mk(0, 2, 1, 32'h100, 32'h200, 32'h300, 0, 0, 0, 3,
                32'h200, 32'h300, 32'h201, 32'h0, 3);
    tbl[4] = mk(2, 2, 2, 32'h40, 32'h50, 32'h60, 0, 1, 0, 4,
                32'h40, 32'h50, 32'h60, 32'h41, 6);
    tbl[5] = mk(1, 1, 1, 32'h7000, 32'h8000, 32'h9000, 0, 0, 1, 3,
                32'h7000, 32'h8000, 32'h9000, 32'h0, 3);

    do_reset();
    chk("reset_read",     64'(WB_SRAM_read_o), 64'd0);
    chk("reset_addr",     64'(WB_SRAM_address_o), 64'd0);
    chk("reset_valid",    64'(rsp_valid_o), 64'd0);
    chk("reset_busy",     64'(busy_o), 64'd0);
    chk("reset_finished", 64'(finished_o), 64'd0);
    chk("reset_data_ch0", rsp_data_o[63:0], 64'd0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // all lengths zero: ARB then DONE, no read at all
    do_reset();
    n_addr = 0; fin_cnt = 0;
    ch_len_i = '0;
    @(posedge clock_i); #1; start_i = 1'b1;
    @(posedge clock_i); #1; start_i = 1'b0;
    chk("zero_busy_c1",     64'(busy_o), 64'd1);
    chk("zero_finished_c1", 64'(finished_o), 64'd0);
    @(posedge clock_i); #1;
    chk("zero_finished_c2", 64'(finished_o), 64'd1);
    chk("zero_busy_c2",     64'(busy_o), 64'd0);
    @(posedge clock_i); #1;
    chk("zero_finished_c3", 64'(finished_o), 64'd0);
    repeat (3) @(posedge clock_i);
    #1;
    chk("zero_no_reads",   64'(n_addr), 64'd0);
    chk("zero_fin_count",  64'(fin_cnt), 64'd1);

    // reset while a read is outstanding
    do_reset();
    sram_lat = 5;
    n_addr = 0;
    got[0] = 0; got[1] = 0; got[2] = 0;
    cur_base[0] = 32'hA000; cur_base[1] = 32'hB000; cur_base[2] = 32'hC000;
    idx_start_addr_i = 32'hA000; uniq_start_addr_i = 32'hB000; rep_start_addr_i = 32'hC000;
    ch_len_i = {CNT_W'(2), CNT_W'(2), CNT_W'(2)};
    rsp_ready_i = 3'b111;
    @(posedge clock_i); #1; start_i = 1'b1;
    @(posedge clock_i); #1; start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clock_i); #1;
      if (WB_SRAM_read_o) seen = 1'b1;
    end
    chk("midrst_read_seen", 64'(seen), 64'd1);
    chk("midrst_addr_before", 64'(WB_SRAM_address_o), 64'hA000);
    @(negedge clock_i);
    reset_i = 1'b1;
    #1;
    chk("midrst_read",     64'(WB_SRAM_read_o), 64'd0);
    chk("midrst_addr",     64'(WB_SRAM_address_o), 64'd0);
    chk("midrst_valid",    64'(rsp_valid_o), 64'd0);
    chk("midrst_busy",     64'(busy_o), 64'd0);
    chk("midrst_finished", 64'(finished_o), 64'd0);
    @(posedge clock_i); #1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    sram_lat = 1;
    run_vec(tbl[5], "vec5_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
